// File: rtl/binary_decoder_2to4_stream.sv
// binary_decoder_2to4_stream
//   Registered 2-to-4 binary decoder. Accepts 2-bit codes over a valid/ready
//   handshake, decodes them to one-hot words, buffers the words in a DEPTH-entry
//   FIFO and presents them downstream over a second valid/ready handshake.
//   Saturating per-line hit counters record every enabled decode.
//
// Parameters
//   DEPTH  output buffer entries (power of 2, >= 2)
//   CNT_W  width of each per-line hit counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   [1:0] code to decode
//   din_en     in   decode enable; 0 decodes to 4'b0000
//   din_valid  in   din/din_en valid
//   din_ready  out  a code can be accepted this cycle
//   out        out  [3:0] one-hot word at the FIFO head (0 when empty)
//   out_valid  out  out holds a valid word
//   out_ready  in   downstream consumes out this cycle
//   clr_cnt    in   synchronous clear of all hit counters
//   cnt_sel    in   [1:0] selects the counter shown on cnt_out
//   cnt_out    out  [CNT_W-1:0] selected hit counter value
module binary_decoder_2to4_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       din,
    input  logic             din_en,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [3:0]       out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [3:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_cnt [4];

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_word;

    function automatic logic [3:0] decode(input logic [1:0] code, input logic en);
        return en ? (4'b0001 << code) : 4'b0000;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Ready ignores a same-cycle pop: a full buffer never passes data through.
    assign din_ready = !w_full && !rst;
    assign out_valid = !w_empty;
    assign out       = w_empty ? 4'b0000 : r_mem[r_rptr];
    assign cnt_out   = r_cnt[cnt_sel];

    assign w_push = din_valid && din_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_word = decode(din, din_en);

    // Storage carries no reset; out is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so the increment wraps modulo DEPTH.
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear takes priority over a counted push in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clr_cnt) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_push && din_en) begin
            r_cnt[din] <= sat_inc(r_cnt[din]);
        end
    end

endmodule

// File: tb/tb_binary_decoder_2to4_stream.sv
module tb_binary_decoder_2to4_stream;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       din = '0;
    logic             din_en = 1'b0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [3:0]       out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [1:0]       cnt_sel = '0;
    logic [CNT_W-1:0] cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of decoded words plus integer hit counts.
    logic [3:0] mq [$];
    int         mcnt [4];

    binary_decoder_2to4_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_cnt   (clr_cnt),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_head();
        return (mq.size() != 0) ? mq[0] : 4'b0000;
    endfunction

    function automatic logic [10:0] m_expect();
        return {1'b0, logic'(mq.size() < DEPTH), logic'(mq.size() != 0), m_head(),
                2'b00, CNT_W'(mcnt[cnt_sel])};
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
    endtask

    // Advance one clock from a falling edge to the next, updating the model.
    task automatic cycle();
        bit         push;
        bit         pop;
        logic [3:0] w;
        push = din_valid && (mq.size() < DEPTH);
        pop  = out_ready && (mq.size() != 0);
        w    = din_en ? (4'd1 << din) : 4'd0;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(w);
        if (clr_cnt) begin
            for (int i = 0; i < 4; i++) mcnt[i] = 0;
        end else if (push && din_en) begin
            if (mcnt[din] < CMAX) mcnt[din]++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            n_tests++;
            if ({din_ready, out_valid, out, cnt_out} !== {1'b0, 1'b0, 4'b0000, {CNT_W{1'b0}}}) begin
                n_fail++;
                $display("FAIL reset sel=%0d: ready=%b valid=%b out=%b cnt=%0d, required 0 0 0000 0",
                         s, din_ready, out_valid, out, cnt_out);
            end
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_decodes();
        din_valid = 1'b1; din_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 2'(i);
            cycle();
            n_tests++;
            if ({out_valid, out} !== {1'b1, 4'(1 << i)}) begin
                n_fail++;
                $display("FAIL single din=%0d: valid=%b out=%b, required 1 %b", i, out_valid, out, 4'(1 << i));
            end
        end
        din_valid = 1'b0;
        cycle();
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            n_tests++;
            if (cnt_out !== CNT_W'(1)) begin
                n_fail++;
                $display("FAIL single_cnt sel=%0d: got %0d, required 1", s, cnt_out);
            end
        end
    endtask

    task automatic test_disable();
        din = 2'b10; din_en = 1'b0; din_valid = 1'b1; out_ready = 1'b1; cnt_sel = 2'd2;
        cycle();
        din_valid = 1'b0;
        n_tests++;
        if ({out_valid, out, cnt_out} !== {1'b1, 4'b0000, CNT_W'(1)}) begin
            n_fail++;
            $display("FAIL disable: valid=%b out=%b cnt2=%0d, required 1 0000 1", out_valid, out, cnt_out);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; din_valid = 1'b1; din_en = 1'b1;
        din = 2'b01; cycle();
        din = 2'b11; cycle();
        din = 2'b00;
        n_tests++;
        if ({din_ready, out_valid, out} !== {1'b0, 1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL bp_full: ready=%b valid=%b out=%b, required 0 1 0010", din_ready, out_valid, out);
        end
        cycle();
        out_ready = 1'b1;
        n_tests++;
        if ({din_ready, out} !== {1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL bp_nopass: ready=%b out=%b, required 0 0010", din_ready, out);
        end
        cycle();
        n_tests++;
        if ({din_ready, out_valid, out} !== {1'b1, 1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL bp_second: ready=%b valid=%b out=%b, required 1 1 1000", din_ready, out_valid, out);
        end
        cycle();
        din_valid = 1'b0;
        n_tests++;
        if ({out_valid, out} !== {1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL bp_third: valid=%b out=%b, required 1 0001", out_valid, out);
        end
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        out_ready = 1'b0; din_valid = 1'b1; din_en = 1'b1;
        din = 2'($urandom_range(0, 3));
        prev = 4'd1 << din;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 2'($urandom_range(0, 3));
            n_tests++;
            if ({din_ready, out_valid, out} !== {1'b1, 1'b1, prev}) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: ready=%b valid=%b out=%b, required 1 1 %b",
                         i, din_ready, out_valid, out, prev);
            end
            prev = 4'd1 << din;
            cycle();
        end
        din_valid = 1'b0;
        n_tests++;
        if ({out_valid, out} !== {1'b1, prev}) begin
            n_fail++;
            $display("FAIL b2b_last: valid=%b out=%b, required 1 %b", out_valid, out, prev);
        end
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_occupancy: valid=%b after one pop, required 0", out_valid);
        end
    endtask

    task automatic test_saturation_clear();
        din_valid = 1'b0; clr_cnt = 1'b1; cnt_sel = 2'd3; out_ready = 1'b1;
        cycle();
        clr_cnt = 1'b0; din_valid = 1'b1; din_en = 1'b1; din = 2'b11;
        for (int i = 0; i < 5; i++) cycle();
        din_valid = 1'b0;
        cycle();
        n_tests++;
        if (cnt_out !== CNT_W'(CMAX)) begin
            n_fail++;
            $display("FAIL saturate: cnt3=%0d, required %0d", cnt_out, CMAX);
        end
        din_valid = 1'b1; clr_cnt = 1'b1;
        cycle();
        din_valid = 1'b0; clr_cnt = 1'b0;
        n_tests++;
        if ({cnt_out, out_valid, out} !== {CNT_W'(0), 1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL clear_wins: cnt3=%0d valid=%b out=%b, required 0 1 1000", cnt_out, out_valid, out);
        end
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; din_valid = 1'b1; din_en = 1'b1;
        din = 2'b10; cycle();
        din = 2'b01; cycle();
        din_valid = 1'b0; cnt_sel = 2'd2;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({din_ready, out_valid, out, cnt_out} !== {1'b0, 1'b0, 4'b0000, CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL async_rst: ready=%b valid=%b out=%b cnt=%0d, required 0 0 0000 0",
                     din_ready, out_valid, out, cnt_out);
        end
        #1 rst = 1'b0;
        model_clear();
        #0.1;
        n_tests++;
        if (din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b, required 1", din_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if ({out_valid, out} !== 5'b0) begin
                n_fail++;
                $display("FAIL rst_stale cycle %0d: valid=%b out=%b, required 0 0000", i, out_valid, out);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din       = 2'($urandom_range(0, 3));
            din_en    = ($urandom_range(0, 4) != 0);
            din_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_cnt   = ($urandom_range(0, 40) == 0);
            cnt_sel   = 2'($urandom_range(0, 3));
            #1;
            n_tests++;
            if ({3'b0, din_ready, out_valid, out, 2'b0, cnt_out} !== {2'b0, m_expect()}) begin
                n_fail++;
                $display("FAIL random cycle %0d: ready=%b valid=%b out=%b cnt[%0d]=%0d, required %b",
                         i, din_ready, out_valid, out, cnt_sel, cnt_out, m_expect());
            end
            cycle();
        end
        din_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_decodes();
        test_disable();
        test_backpressure();
        test_back_to_back();
        test_saturation_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
